// File: rtl/rc4_ctrl_pkg.sv
// rc4_ctrl_pkg: shared state type, byte width and counter widths for the RC4 stream controller.
package rc4_ctrl_pkg;
  localparam int BYTE_W = 8;
  localparam int KEY_LEN_DEF = 16;
  localparam int MAX_BYTES_DEF = 65535;
  localparam int INIT_TIMEOUT_DEF = 1024;
  localparam int DROP_N_DEF = 256;

  typedef enum logic [2:0] {IDLE, KEYLOAD, WAIT_INIT, DROP, RUN, DRAIN} state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int KEY_CNT_W = cnt_w(KEY_LEN_DEF);
  localparam int BYTE_CNT_W = cnt_w(MAX_BYTES_DEF);
  localparam int TIMER_W = cnt_w(INIT_TIMEOUT_DEF);
  localparam int DROP_CNT_W = cnt_w(DROP_N_DEF);
endpackage

// File: rtl/rc4_ctrl_out_fifo.sv
// rc4_ctrl_out_fifo: 2-entry byte FIFO with valid/ready on both sides, async active-low reset.
module rc4_ctrl_out_fifo
  import rc4_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [BYTE_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);
  logic [BYTE_W-1:0] mem_q [2];
  logic wr_q, rd_q, push, pop;
  logic [1:0] cnt_q;

  assign in_ready_o = cnt_q != 2'd2;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o = mem_q[rd_q];
  assign push = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wr_q] <= in_data_i;
      wr_q <= wr_q ^ push;
      rd_q <= rd_q ^ pop;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: RC4 session sequencer - key load, init wait, keystream prefetch, XOR streaming.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes after init.
module rc4_stream_ctrl
  import rc4_ctrl_pkg::*;
#(
  parameter int KEY_LEN      = KEY_LEN_DEF,
  parameter int MAX_BYTES    = MAX_BYTES_DEF,
  parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEF,
  parameter int DROP_N       = DROP_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] key_byte,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              core_restart,
  output logic [BYTE_W-1:0] core_password,
  output logic              core_valid,
  input  logic              core_init_done,
  output logic              core_ks_req,
  input  logic [BYTE_W-1:0] core_ks,
  input  logic              core_ks_valid,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              limit_hit,
  output logic              err
);
`ifdef RC4_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  localparam int KW = cnt_w(KEY_LEN);
  localparam int BW = cnt_w(MAX_BYTES);
  localparam int TW = cnt_w(INIT_TIMEOUT);
  localparam int DW = cnt_w(DROP_N);

  state_e state_q, state_d;
  logic [KW-1:0] key_cnt_q, key_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic [BYTE_W-1:0] ks_buf_q, ks_buf_d, pwd_q, pwd_d;
  logic ks_full_q, ks_full_d, pend_q, pend_d;
  logic restart_q, restart_d, cvalid_q, cvalid_d;
  logic limit_q, limit_d, err_q, err_d;
  logic key_acc, in_acc, ks_take, fifo_rdy, under_max;

  assign under_max = byte_cnt_q < BW'(MAX_BYTES);
  assign busy = state_q != IDLE;
  assign key_ready = state_q == KEYLOAD;
  assign key_acc = key_valid & key_ready;
  assign in_ready = (state_q == RUN) & ks_full_q & fifo_rdy & under_max;
  assign in_acc = in_valid & in_ready;
  // At most one keystream request in flight; a response without one is ignored.
  assign core_ks_req = ((state_q == DROP) | ((state_q == RUN) & under_max)) & ~ks_full_q & ~pend_q;
  assign ks_take = core_ks_valid & pend_q;
  assign core_restart = restart_q;
  assign core_password = pwd_q;
  assign core_valid = cvalid_q;
  assign limit_hit = limit_q;
  assign err = err_q;

  rc4_ctrl_out_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .in_data_i   (data_in ^ ks_buf_q),
    .in_valid_i  (in_acc),
    .in_ready_o  (fifo_rdy),
    .out_data_o  (data_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always_comb begin
    state_d = state_q;
    key_cnt_d = key_cnt_q;
    byte_cnt_d = byte_cnt_q;
    timer_d = timer_q;
    drop_cnt_d = drop_cnt_q;
    ks_buf_d = ks_buf_q;
    ks_full_d = ks_full_q;
    pend_d = pend_q | core_ks_req;
    restart_d = 1'b0;
    cvalid_d = key_acc;
    pwd_d = key_acc ? key_byte : pwd_q;
    limit_d = limit_q;
    err_d = err_q;
    if (ks_take) begin
      pend_d = 1'b0;
      ks_buf_d = (state_q == DROP) ? ks_buf_q : core_ks;
      ks_full_d = state_q != DROP;
    end
    case (state_q)
      IDLE:
        if (start) begin
          state_d = KEYLOAD;
          restart_d = 1'b1;
          key_cnt_d = '0;
          byte_cnt_d = '0;
          limit_d = 1'b0;
          err_d = 1'b0;
          ks_full_d = 1'b0;
          pend_d = 1'b0;
        end
      KEYLOAD:
        if (key_acc) begin
          key_cnt_d = key_cnt_q + 1'b1;
          if (key_cnt_q == KW'(KEY_LEN - 1)) begin
            state_d = WAIT_INIT;
            timer_d = '0;
          end
        end
      WAIT_INIT:
        if (core_init_done) begin
          drop_cnt_d = '0;
          if (DROP_EN) state_d = DROP;
          else state_d = RUN;
        end else if (timer_q == TW'(INIT_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else timer_d = timer_q + 1'b1;
      DROP:
        if (ks_take) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
          if (drop_cnt_q == DW'(DROP_N - 1)) state_d = RUN;
        end
      RUN: begin
        if (in_acc) begin
          ks_full_d = 1'b0;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
        if (!under_max) state_d = DRAIN;
      end
      DRAIN:
        if (!out_valid) begin
          limit_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      key_cnt_q <= '0;
      byte_cnt_q <= '0;
      timer_q <= '0;
      drop_cnt_q <= '0;
      ks_buf_q <= '0;
      ks_full_q <= 1'b0;
      pend_q <= 1'b0;
      restart_q <= 1'b0;
      cvalid_q <= 1'b0;
      pwd_q <= '0;
      limit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_cnt_q <= key_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q <= timer_d;
      drop_cnt_q <= drop_cnt_d;
      ks_buf_q <= ks_buf_d;
      ks_full_q <= ks_full_d;
      pend_q <= pend_d;
      restart_q <= restart_d;
      cvalid_q <= cvalid_d;
      pwd_q <= pwd_d;
      limit_q <= limit_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// tb_rc4_stream_ctrl: directed session sequence with random data/keystream, checked against a keystream-index model.
module tb_rc4_stream_ctrl;
  localparam int KEY_LEN = 16, MAX_BYTES = 10, INIT_TIMEOUT = 8, DROP_N = 4;
`ifdef RC4_DROP_EN
  localparam int DROP_OFS = DROP_N;
`else
  localparam int DROP_OFS = 0;
`endif
  logic clk = 0, rst = 0, start = 0, key_valid = 0, core_init_done = 0, core_ks_valid = 0;
  logic in_valid = 0, out_ready = 1;
  logic [7:0] key_byte = 0, core_ks = 0, data_in = 0;
  logic key_ready, core_restart, core_valid, core_ks_req, in_ready, out_valid, busy, limit_hit, err;
  logic [7:0] core_password, data_out;
  int passed = 0, total = 0, outs = 0, restarts = 0, sess_acc = 0, ks_n = 0, acc = 0;
  logic [7:0] ks_seq [256];
  logic [7:0] exp_q[$], exp_keys[$], got_keys[$];

  rc4_stream_ctrl #(.KEY_LEN(KEY_LEN), .MAX_BYTES(MAX_BYTES), .INIT_TIMEOUT(INIT_TIMEOUT), .DROP_N(DROP_N)) dut (
    .clk(clk), .rst(rst), .start(start), .key_byte(key_byte), .key_valid(key_valid), .key_ready(key_ready),
    .core_restart(core_restart), .core_password(core_password), .core_valid(core_valid),
    .core_init_done(core_init_done), .core_ks_req(core_ks_req), .core_ks(core_ks), .core_ks_valid(core_ks_valid),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .limit_hit(limit_hit), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Core model: answers each request one cycle later with the next byte of this session's keystream.
  initial forever begin
    @(negedge clk);
    if (core_restart) ks_n = 0;
    if (core_ks_req) begin
      @(posedge clk); #1;
      core_ks = ks_seq[ks_n % 256];
      ks_n++;
      core_ks_valid = 1;
      @(posedge clk); #1;
      core_ks_valid = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (core_valid) got_keys.push_back(core_password);
    if (core_restart) restarts++;
  end

  initial forever begin
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      outs++;
      check("out_data", {24'b0, data_out}, exp_q.size() > 0 ? {24'b0, exp_q.pop_front()} : 32'h100);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic new_session(input bit rnd_ks);
    foreach (ks_seq[i]) ks_seq[i] = rnd_ks ? 8'($urandom) : 8'hAA;
    exp_keys.delete();
    got_keys.delete();
    sess_acc = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic load_keys(input bit rnd);
    int n = 0, cyc = 0;
    key_valid = 1;
    key_byte = rnd ? 8'($urandom) : 8'd0;
    while (n < KEY_LEN && cyc < 100) begin
      @(negedge clk);
      if (key_ready) begin
        exp_keys.push_back(key_byte);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      key_byte = rnd ? 8'($urandom) : 8'(n);
    end
    key_valid = 0;
    check("key_load_accepts", n, KEY_LEN);
  endtask

  task automatic check_keys();
    check("key_count", got_keys.size(), exp_keys.size());
    foreach (exp_keys[i])
      check("key_order", (i < got_keys.size()) ? {24'b0, got_keys[i]} : 32'h100, {24'b0, exp_keys[i]});
  endtask

  // Expected output i of a session is input i XOR keystream byte (dropped bytes + i).
  task automatic drive(input int want, input int cycles, input bit rnd, input logic [7:0] d,
                       input bit rnd_rdy, output int n);
    n = 0;
    for (int c = 0; c < cycles && n < want; c++) begin
      in_valid = 1;
      data_in = rnd ? 8'($urandom) : d;
      if (rnd_rdy) out_ready = 1'($urandom);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(data_in ^ ks_seq[DROP_OFS + sess_acc]);
        sess_acc++;
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    int c = 0;
    while (busy && c < max) begin
      @(posedge clk); #1;
      c++;
    end
    check("idle_reached", busy, 0);
  endtask

  function automatic logic [31:0] out_vec();
    return {7'b0, busy, key_ready, in_ready, out_valid, core_restart, core_valid, core_ks_req,
            limit_hit, err, core_password, data_out};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 0);
    rst = 1;
    @(posedge clk); #1;
    // Session 1: ordered key load, then constant keystream streaming.
    new_session(0);
    check("restart_pulse", core_restart, 1);
    check("keyload_ready", {busy, key_ready}, 2'b11);
    load_keys(0);
    repeat (2) @(posedge clk);
    #1;
    check_keys();
    check("wait_init_state", {busy, key_ready, in_ready}, 3'b100);
    start = 1;
    key_valid = 1;
    key_byte = 8'h77;
    @(posedge clk); #1;
    start = 0;
    key_valid = 0;
    @(posedge clk); #1;
    check("start_ignored_busy", restarts, 1);
    check("key_ignored_outside_load", got_keys.size(), KEY_LEN);
    core_init_done = 1;
    @(posedge clk); #1;
    core_init_done = 0;
    out_ready = 1;
    drive(4, 60, 0, 8'h55, 0, acc);
    check("stream_accepts", acc, 4);
    repeat (4) @(posedge clk);
    #1;
    check("stream_outputs", outs, 4);
    check("stream_drained", exp_q.size(), 0);
    // Backpressure: FIFO holds exactly two bytes.
    out_ready = 0;
    drive(100, 10, 1, 8'h00, 0, acc);
    check("bp_accepts", acc, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_outputs", outs, 6);
    check("bp_drained", exp_q.size(), 0);
    // Byte limit: only MAX_BYTES - 6 more are accepted, then drain and stop.
    drive(6, 40, 1, 8'h00, 0, acc);
    check("limit_accepts", acc, MAX_BYTES - 6);
    wait_idle(50);
    check("limit_flags", {limit_hit, err}, 2'b10);
    check("limit_outputs", outs, MAX_BYTES);
    check("limit_drained", exp_q.size(), 0);
    // Session 2: init timeout.
    new_session(1);
    check("start_clears_limit", {core_restart, limit_hit}, 2'b10);
    load_keys(1);
    repeat (INIT_TIMEOUT - 1) @(posedge clk);
    #1;
    check("timeout_not_yet", {busy, err}, 2'b10);
    @(posedge clk); #1;
    check("timeout_fired", {busy, err}, 2'b01);
    check_keys();
    // Session 3: random stream with random stalls, then reset while the FIFO holds a byte.
    new_session(1);
    check("start_clears_err", {busy, err}, 2'b10);
    load_keys(1);
    core_init_done = 1;
    @(posedge clk); #1;
    core_init_done = 0;
    drive(6, 200, 1, 8'h00, 1, acc);
    check("rand_accepts", acc, 6);
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);
    out_ready = 0;
    drive(1, 30, 1, 8'h00, 0, acc);
    check("pre_reset_accept", acc, 1);
    @(negedge clk);
    check("pre_reset_fifo", {busy, out_valid}, 2'b11);
    #2;
    rst = 0;
    #1;
    check("midrun_reset_outputs", out_vec(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1;
    out_ready = 1;
    // Session 4: clean restart after reset.
    new_session(1);
    load_keys(1);
    core_init_done = 1;
    @(posedge clk); #1;
    core_init_done = 0;
    drive(3, 60, 1, 8'h00, 0, acc);
    check("post_reset_accepts", acc, 3);
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_drained", exp_q.size(), 0);
    check("restart_count", restarts, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
